// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : alu_pkg
//  Description : Shared datapath sizing constants for the structural ALU.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_DEPTH = 8;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/reg_cell.sv
`default_nettype none
// ============================================================================
//  Module      : reg_cell
//  Description : WIDTH-bit enabled register, synchronous active-high reset,
//                built from per-bit flip-flops.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_cell
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    generate
        for (genvar g = 0; g < WIDTH; g++) begin : g_bit
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_q[g] <= 1'b0;
                end else if (en) begin
                    r_q[g] <= d[g];
                end
            end
        end
    endgenerate

    assign q = r_q;

endmodule : reg_cell
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
//  Module      : register_file
//  Description : DEPTH x WIDTH register file, one write port, two combinational
//                read ports, optional hardwired zero register and write bypass.
//  Revision    : 1.0  initial release
// ============================================================================
module register_file
    import alu_pkg::*;
#(
    parameter int WIDTH    = ALU_WIDTH,
    parameter int DEPTH    = ALU_DEPTH,
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b
);

    logic [DEPTH-1:0] w_en;
    logic [WIDTH-1:0] w_q [DEPTH];
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;

    // One-hot write decode; out-of-range addresses match no cell and are dropped.
    always_comb begin
        w_en = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (we && !rst && (waddr == ADDR_W'(i)) && !(ZERO_REG && (i == 0))) begin
                w_en[i] = 1'b1;
            end
        end
    end

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_cell
            reg_cell #(
                .WIDTH (WIDTH)
            ) u_cell (
                .clk (clk),
                .rst (rst),
                .en  (w_en[g]),
                .d   (wdata),
                .q   (w_q[g])
            );
        end
    endgenerate

    // Bypass keys off the decoded enable, so ignored writes are never forwarded.
    always_comb begin
        w_rd_a = '0;
        w_rd_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((raddr_a == ADDR_W'(i)) && !(ZERO_REG && (i == 0))) begin
                w_rd_a = (BYPASS && w_en[i]) ? wdata : w_q[i];
            end
            if ((raddr_b == ADDR_W'(i)) && !(ZERO_REG && (i == 0))) begin
                w_rd_b = (BYPASS && w_en[i]) ? wdata : w_q[i];
            end
        end
        if (rst) begin
            w_rd_a = '0;
            w_rd_b = '0;
        end
    end

    assign rdata_a = w_rd_a;
    assign rdata_b = w_rd_b;

endmodule : register_file
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file
//  Description : Self-checking bench for register_file across three configs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_register_file;

    // cfg0: bypass, cfg1: no bypass, cfg2: zero reg + DEPTH=6 + bypass
    localparam int NCFG       = 3;
    localparam int DEP_K [3]  = '{8, 8, 6};
    localparam bit ZERO_K [3] = '{1'b0, 1'b0, 1'b1};
    localparam bit BYP_K [3]  = '{1'b1, 1'b0, 1'b1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [2:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  raddr_a = '0;
    logic [2:0]  raddr_b = '0;
    logic [31:0] rda [NCFG];
    logic [31:0] rdb [NCFG];

    logic [31:0] m [NCFG][8];
    int n_err = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    register_file #(.WIDTH(32), .DEPTH(8), .ZERO_REG(1'b0), .BYPASS(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rda[0]), .raddr_b(raddr_b), .rdata_b(rdb[0]));

    register_file #(.WIDTH(32), .DEPTH(8), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rda[1]), .raddr_b(raddr_b), .rdata_b(rdb[1]));

    register_file #(.WIDTH(32), .DEPTH(6), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut2 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rda[2]), .raddr_b(raddr_b), .rdata_b(rdb[2]));

    typedef struct {
        logic        r;
        logic        w;
        logic [2:0]  wa;
        logic [31:0] wd;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    vec_t tbl [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference read: what a reader sees this cycle under the config's rules.
    function automatic logic [31:0] exp_rd(input int k, input logic [2:0] a);
        if (rst) return 32'h0;
        if (int'(a) >= DEP_K[k]) return 32'h0;
        if (ZERO_K[k] && a == 3'd0) return 32'h0;
        if (BYP_K[k] && we && waddr == a) return wdata;
        return m[k][a];
    endfunction

    task automatic apply(input logic r, input logic w, input logic [2:0] wa,
                         input logic [31:0] wd, input logic [2:0] a, input logic [2:0] b);
        rst = r; we = w; waddr = wa; wdata = wd; raddr_a = a; raddr_b = b;
        @(negedge clk);
        for (int k = 0; k < NCFG; k++) begin
            check($sformatf("model cfg%0d A addr%0d", k, a), rda[k], exp_rd(k, a));
            check($sformatf("model cfg%0d B addr%0d", k, b), rdb[k], exp_rd(k, b));
        end
    endtask

    task automatic commit();
        @(posedge clk);
        for (int k = 0; k < NCFG; k++) begin
            if (rst) begin
                for (int j = 0; j < 8; j++) m[k][j] = 32'h0;
            end else if (we && int'(waddr) < DEP_K[k] && !(ZERO_K[k] && waddr == 3'd0)) begin
                m[k][waddr] = wdata;
            end
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] snap [6];
        logic [2:0]  wa;

        for (int k = 0; k < NCFG; k++)
            for (int j = 0; j < 8; j++) m[k][j] = 32'h0;

        // {rst, we, waddr, wdata, raddr_a, raddr_b, exp_a, exp_b} for cfg0
        tbl[0]  = '{1'b1, 1'b0, 3'd0, 32'h0,        3'd0, 3'd0, 32'h0,        32'h0};
        tbl[1]  = '{1'b0, 1'b1, 3'd3, 32'hDEADBEEF, 3'd3, 3'd0, 32'hDEADBEEF, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 3'd0, 32'h0,        3'd3, 3'd3, 32'h0,        32'h0};
        tbl[3]  = '{1'b0, 1'b0, 3'd0, 32'h0,        3'd3, 3'd3, 32'h0,        32'h0};
        tbl[4]  = '{1'b0, 1'b1, 3'd1, 32'h11111111, 3'd2, 3'd3, 32'h0,        32'h0};
        tbl[5]  = '{1'b0, 1'b1, 3'd2, 32'h22222222, 3'd1, 3'd3, 32'h11111111, 32'h0};
        tbl[6]  = '{1'b0, 1'b0, 3'd0, 32'h0,        3'd1, 3'd2, 32'h11111111, 32'h22222222};
        tbl[7]  = '{1'b0, 1'b0, 3'd0, 32'h0,        3'd2, 3'd2, 32'h22222222, 32'h22222222};
        tbl[8]  = '{1'b0, 1'b1, 3'd5, 32'hA5A5A5A5, 3'd0, 3'd1, 32'h0,        32'h11111111};
        tbl[9]  = '{1'b0, 1'b1, 3'd5, 32'h5A5A5A5A, 3'd5, 3'd5, 32'h5A5A5A5A, 32'h5A5A5A5A};
        tbl[10] = '{1'b0, 1'b0, 3'd0, 32'h0,        3'd5, 3'd4, 32'h5A5A5A5A, 32'h0};
        tbl[11] = '{1'b1, 1'b1, 3'd4, 32'h12345678, 3'd4, 3'd4, 32'h0,        32'h0};
        tbl[12] = '{1'b0, 1'b0, 3'd0, 32'h0,        3'd4, 3'd5, 32'h0,        32'h0};
        tbl[13] = '{1'b0, 1'b1, 3'd4, 32'h12345678, 3'd0, 3'd4, 32'h0,        32'h12345678};
        tbl[14] = '{1'b0, 1'b0, 3'd0, 32'h0,        3'd4, 3'd4, 32'h12345678, 32'h12345678};
        tbl[15] = '{1'b0, 1'b1, 3'd0, 32'hFFFFFFFF, 3'd0, 3'd1, 32'hFFFFFFFF, 32'h0};
        tbl[16] = '{1'b0, 1'b1, 3'd7, 32'hCAFEF00D, 3'd7, 3'd6, 32'hCAFEF00D, 32'h0};
        tbl[17] = '{1'b0, 1'b0, 3'd0, 32'h0,        3'd7, 3'd0, 32'hCAFEF00D, 32'hFFFFFFFF};
        tbl[18] = '{1'b0, 1'b1, 3'd2, 32'h00000001, 3'd2, 3'd3, 32'h00000001, 32'h0};
        tbl[19] = '{1'b0, 1'b1, 3'd2, 32'h00000002, 3'd2, 3'd3, 32'h00000002, 32'h0};
        tbl[20] = '{1'b0, 1'b0, 3'd0, 32'h0,        3'd2, 3'd2, 32'h00000002, 32'h00000002};

        for (int i = 0; i < 21; i++) begin
            apply(tbl[i].r, tbl[i].w, tbl[i].wa, tbl[i].wd, tbl[i].ra, tbl[i].rb);
            check($sformatf("tbl%0d A", i), rda[0], tbl[i].ea);
            check($sformatf("tbl%0d B", i), rdb[0], tbl[i].eb);
            commit();
        end

        // Non-bypassed config sees old contents during the write cycle.
        apply(1'b0, 1'b1, 3'd5, 32'hA5A5A5A5, 3'd0, 3'd0);
        commit();
        apply(1'b0, 1'b1, 3'd5, 32'h5A5A5A5A, 3'd5, 3'd5);
        check("nobyp write cycle A", rda[1], 32'hA5A5A5A5);
        check("byp write cycle A", rda[0], 32'h5A5A5A5A);
        commit();
        apply(1'b0, 1'b0, 3'd0, 32'h0, 3'd5, 3'd5);
        check("nobyp next cycle A", rda[1], 32'h5A5A5A5A);
        commit();

        // Hardwired zero register, including under bypass.
        apply(1'b0, 1'b1, 3'd0, 32'hFFFFFFFF, 3'd0, 3'd0);
        check("zero reg write cycle", rda[2], 32'h0);
        commit();
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 3'd0, 32'h0, 3'd0, 3'd0);
            check("zero reg after write", rda[2], 32'h0);
            commit();
        end

        // Out-of-range write on DEPTH=6 leaves registers 0..5 untouched.
        for (int i = 1; i < 6; i++) begin
            wa = 3'(i);
            apply(1'b0, 1'b1, wa, 32'h01010101 * i, 3'd0, 3'd0);
            commit();
        end
        for (int i = 0; i < 6; i++) snap[i] = m[2][i];
        apply(1'b0, 1'b1, 3'd7, 32'hCAFEF00D, 3'd7, 3'd6);
        check("oor write cycle addr7", rda[2], 32'h0);
        check("oor write cycle addr6", rdb[2], 32'h0);
        commit();
        apply(1'b0, 1'b0, 3'd0, 32'h0, 3'd7, 3'd6);
        check("oor after addr7", rda[2], 32'h0);
        check("oor after addr6", rdb[2], 32'h0);
        commit();
        for (int i = 0; i < 6; i++) begin
            wa = 3'(i);
            apply(1'b0, 1'b0, 3'd0, 32'h0, wa, wa);
            check($sformatf("oor unchanged reg%0d", i), rda[2], snap[i]);
            commit();
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 500; i++) begin
            logic r;
            logic w;
            logic [2:0] a;
            logic [2:0] b;
            r  = ($urandom_range(0, 31) == 0);
            w  = ($urandom_range(0, 3) != 0);
            wa = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 2) == 0) ? wa : 3'($urandom_range(0, 7));
            b  = ($urandom_range(0, 2) == 0) ? wa : 3'($urandom_range(0, 7));
            apply(r, w, wa, $urandom, a, b);
            commit();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_register_file
`default_nettype wire
